sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 35 +++
 rtl/sram_wait_ctr.sv | 37 +++
 rtl/sram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM initiator:
//   sram_ctrl_state_t : controller state encoding
//   ctr_width()       : wait-counter width for a given pair of strobe lengths
//   CTR_W_MIN         : smallest counter width ever used
//   DEF_CTR_W         : counter width for the default 2/2 wait-state setup
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WR_PULSE = 3'd2,
    ST_RD_PULSE = 3'd3,
    ST_DONE     = 3'd4
  } sram_ctrl_state_t;

  localparam int CTR_W_MIN       = 1;
  localparam int DEF_WE_CYCLES   = 2;
  localparam int DEF_RD_CYCLES   = 2;

  // The counter only ever holds (cycles - 1), so $clog2(max cycles) bits are
  // enough; a single-cycle strobe would give 0, hence the floor.
  function automatic int ctr_width(input int we_cycles, input int rd_cycles);
    int m;
    int w;
    m = (we_cycles > rd_cycles) ? we_cycles : rd_cycles;
    w = $clog2(m);
    return (w < CTR_W_MIN) ? CTR_W_MIN : w;
  endfunction

  localparam int DEF_CTR_W = ctr_width(DEF_WE_CYCLES, DEF_RD_CYCLES);

endpackage

// File: rtl/sram_wait_ctr.sv
// -----------------------------------------------------------------------------
// sram_wait_ctr
// Loadable down-counter timing the strobe pulses. Counts down to zero and
// stays there until the next load.
//   CLK      in  system clock
//   RST      in  synchronous active-high reset (count -> 0)
//   LOAD     in  load LOAD_VAL on the next rising edge
//   LOAD_VAL in  W   value to load
//   ZERO     out count is zero (terminal count)
// -----------------------------------------------------------------------------
module sram_wait_ctr
  import sram_ctrl_pkg::*;
#(
  parameter int W = DEF_CTR_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  output logic         ZERO
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (LOAD) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign ZERO = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Synchronous initiator for an asynchronous SRAM. Turns a valid/ready request
// stream into registered ADDR/WDATA/N_WE/N_OE pin activity with programmable
// write and read strobe lengths, and reports completion with a one-cycle
// response pulse.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | ready for a request; strobes high
// ST_SETUP    | address/data driven, strobes still high (setup time)
// ST_WR_PULSE | N_WE low for WE_CYCLES cycles
// ST_RD_PULSE | N_OE low for RD_CYCLES cycles; RDATA sampled on the last edge
// ST_DONE     | strobes high, pins held (hold time), RSP_VALID high
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ_VALID/REQ_READY      request handshake
//   REQ_WRITE/ADDR/DATA      request payload
//   RSP_VALID/WRITE/DATA     completion pulse, op type, last read data
//   ADDR, WDATA, RDATA       SRAM address / write data / read data pins
//   N_WE, N_OE               SRAM active-low strobes
// -----------------------------------------------------------------------------
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH     = 12,
  parameter int WIDTH     = 8,
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WRITE,
  input  logic [DEPTH-1:0] REQ_ADDR,
  input  logic [WIDTH-1:0] REQ_DATA,
  output logic             RSP_VALID,
  output logic             RSP_WRITE,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [DEPTH-1:0] ADDR,
  output logic [WIDTH-1:0] WDATA,
  input  logic [WIDTH-1:0] RDATA,
  output logic             N_WE,
  output logic             N_OE
);

  if (WE_CYCLES < 1) begin : g_bad_we_cycles
    $error("sram_ctrl: WE_CYCLES must be >= 1");
  end
  if (RD_CYCLES < 1) begin : g_bad_rd_cycles
    $error("sram_ctrl: RD_CYCLES must be >= 1");
  end

  localparam int CTR_W = ctr_width(WE_CYCLES, RD_CYCLES);
  localparam logic [CTR_W-1:0] WE_LOAD = CTR_W'(WE_CYCLES - 1);
  localparam logic [CTR_W-1:0] RD_LOAD = CTR_W'(RD_CYCLES - 1);

  sram_ctrl_state_t r_state;
  logic             r_is_write;
  logic [DEPTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_n_we;
  logic             r_n_oe;
  logic             r_rsp_valid;
  logic             r_rsp_write;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_accept;
  logic             w_ctr_load;
  logic [CTR_W-1:0] w_ctr_val;
  logic             w_ctr_zero;

  assign REQ_READY  = (r_state == ST_IDLE) && !RST;
  assign w_accept   = REQ_VALID && REQ_READY;

  // The counter is armed in SETUP so that it already holds (cycles - 1) in the
  // first strobe cycle; zero then marks the last strobe cycle.
  assign w_ctr_load = (r_state == ST_SETUP);
  assign w_ctr_val  = r_is_write ? WE_LOAD : RD_LOAD;

  sram_wait_ctr #(
    .W        (CTR_W)
  ) u_wait_ctr (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (w_ctr_load),
    .LOAD_VAL (w_ctr_val),
    .ZERO     (w_ctr_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_n_we      <= 1'b1;
      r_n_oe      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr     <= REQ_ADDR;
            r_wdata    <= REQ_DATA;
            r_is_write <= REQ_WRITE;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_is_write) begin
            r_n_we  <= 1'b0;
            r_state <= ST_WR_PULSE;
          end else begin
            r_n_oe  <= 1'b0;
            r_state <= ST_RD_PULSE;
          end
        end
        ST_WR_PULSE: begin
          if (w_ctr_zero) begin
            r_n_we      <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_RD_PULSE: begin
          if (w_ctr_zero) begin
            r_n_oe      <= 1'b1;
            r_rsp_data  <= RDATA;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ADDR      = r_addr;
  assign WDATA     = r_wdata;
  assign N_WE      = r_n_we;
  assign N_OE      = r_n_oe;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_WRITE = r_rsp_write;
  assign RSP_DATA  = r_rsp_data;

`ifdef FORMAL
  a_one_strobe : assert property (@(posedge CLK) r_n_we || r_n_oe);
  a_wr_stable  : assert property (@(posedge CLK)
                   (!r_n_we && $past(!r_n_we)) |-> ($stable(r_addr) && $stable(r_wdata)));
  a_rd_stable  : assert property (@(posedge CLK)
                   (!r_n_oe && $past(!r_n_oe)) |-> $stable(r_addr));
  a_we_edges   : assert property (@(posedge CLK)
                   $changed(r_n_we) |-> (r_state == ST_WR_PULSE ||
                                         $past(r_state) == ST_WR_PULSE));
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Bench for sram_ctrl paired with a behavioural asynchronous SRAM.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int DEPTH = 12;
  localparam int WIDTH = 8;
  localparam int WE    = 2;
  localparam int RD    = 2;

  // Strobe-low cycles, counted from the accept edge (bit n = cycle n).
  localparam int WR_MASK = ((1 << WE) - 1) << 2;
  localparam int RD_MASK = ((1 << RD) - 1) << 2;

  logic             CLK;
  logic             RST;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_WRITE;
  logic [DEPTH-1:0] REQ_ADDR;
  logic [WIDTH-1:0] REQ_DATA;
  logic             RSP_VALID;
  logic             RSP_WRITE;
  logic [WIDTH-1:0] RSP_DATA;
  logic [DEPTH-1:0] ADDR;
  logic [WIDTH-1:0] WDATA;
  logic [WIDTH-1:0] RDATA;
  logic             N_WE;
  logic             N_OE;

  int checks   = 0;
  int failures = 0;

  sram_ctrl #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .WE_CYCLES (WE),
    .RD_CYCLES (RD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .RSP_VALID (RSP_VALID),
    .RSP_WRITE (RSP_WRITE),
    .RSP_DATA  (RSP_DATA),
    .ADDR      (ADDR),
    .WDATA     (WDATA),
    .RDATA     (RDATA),
    .N_WE      (N_WE),
    .N_OE      (N_OE)
  );

  // Behavioural SRAM: asynchronous read, word written while N_WE is low.
  logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
  always @(posedge CLK) if (N_WE === 1'b0) mem[ADDR] <= WDATA;
  assign RDATA = mem[ADDR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Results of the most recent run_req call.
  int               res_stall;
  int               res_rsp_cyc;
  int               res_we_mask;
  int               res_oe_mask;
  int               res_viol;
  int               res_busy;
  logic             res_rw;
  logic [WIDTH-1:0] res_rdat;

  // Presents one request (holding it until accepted) and observes it until
  // its response pulse. Called and returns at a falling edge.
  task automatic run_req(input logic w, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    res_stall = 0; res_rsp_cyc = 0; res_we_mask = 0; res_oe_mask = 0;
    res_viol = 0; res_busy = 0; res_rw = 1'b0; res_rdat = '0;
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_DATA = d;
    while (REQ_READY !== 1'b1 && res_stall < 50) begin
      @(negedge CLK);
      res_stall++;
    end
    if (REQ_READY !== 1'b1) begin
      REQ_VALID = 1'b0;
      res_stall = -1;
      return;
    end
    @(posedge CLK);
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'($urandom);
        REQ_ADDR  = DEPTH'($urandom);
        REQ_DATA  = WIDTH'($urandom);
      end
      if (REQ_READY === 1'b0) res_busy++;
      if (N_WE === 1'b0) res_we_mask |= (1 << n);
      if (N_OE === 1'b0) res_oe_mask |= (1 << n);
      if (N_WE === 1'b0 && N_OE === 1'b0) res_viol++;
      if ((N_WE === 1'b0 || N_OE === 1'b0) && ADDR !== a) res_viol++;
      if (N_WE === 1'b0 && WDATA !== d) res_viol++;
      if (RSP_VALID === 1'b1) begin
        if (ADDR !== a || N_WE !== 1'b1 || N_OE !== 1'b1) res_viol++;
        res_rsp_cyc = n;
        res_rw      = RSP_WRITE;
        res_rdat    = RSP_DATA;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 12'h3C3; REQ_DATA = 8'hC3;
    repeat (3) @(negedge CLK);
    checks++; if (N_WE !== 1'b1)     begin failures++; $display("FAIL reset_n_we: got %b want 1", N_WE); end
    checks++; if (N_OE !== 1'b1)     begin failures++; $display("FAIL reset_n_oe: got %b want 1", N_OE); end
    checks++; if (ADDR !== '0)       begin failures++; $display("FAIL reset_addr: got %h want 000", ADDR); end
    checks++; if (WDATA !== '0)      begin failures++; $display("FAIL reset_wdata: got %h want 00", WDATA); end
    checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
    checks++; if (RSP_WRITE !== 1'b0) begin failures++; $display("FAIL reset_rsp_write: got %b want 0", RSP_WRITE); end
    checks++; if (RSP_DATA !== '0)   begin failures++; $display("FAIL reset_rsp_data: got %h want 00", RSP_DATA); end
    checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b want 0", REQ_READY); end
    REQ_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", REQ_READY); end
    checks++; if (N_WE !== 1'b1)     begin failures++; $display("FAIL reset_no_accept: N_WE got %b want 1", N_WE); end
  endtask

  task automatic test_write_read();
    run_req(1'b1, 12'h123, 8'h5A);
    checks++; if (res_stall != 0)      begin failures++; $display("FAIL wr_accept_stall: got %0d want 0", res_stall); end
    checks++; if (res_rsp_cyc != WE+2) begin failures++; $display("FAIL wr_rsp_cycle: got %0d want %0d", res_rsp_cyc, WE+2); end
    checks++; if (res_rw !== 1'b1)     begin failures++; $display("FAIL wr_rsp_write: got %b want 1", res_rw); end
    checks++; if (res_we_mask != WR_MASK) begin failures++; $display("FAIL wr_n_we_cycles: got %0h want %0h", res_we_mask, WR_MASK); end
    checks++; if (res_oe_mask != 0)    begin failures++; $display("FAIL wr_n_oe_cycles: got %0h want 0", res_oe_mask); end
    checks++; if (res_viol != 0)       begin failures++; $display("FAIL wr_pin_rules: got %0d violations want 0", res_viol); end
    checks++; if (res_busy != WE+2)    begin failures++; $display("FAIL wr_ready_low: got %0d cycles want %0d", res_busy, WE+2); end
    run_req(1'b0, 12'h123, 8'h00);
    checks++; if (res_stall != 1)      begin failures++; $display("FAIL rd_accept_stall: got %0d want 1", res_stall); end
    checks++; if (res_rsp_cyc != RD+2) begin failures++; $display("FAIL rd_rsp_cycle: got %0d want %0d", res_rsp_cyc, RD+2); end
    checks++; if (res_rw !== 1'b0)     begin failures++; $display("FAIL rd_rsp_write: got %b want 0", res_rw); end
    checks++; if (res_rdat !== 8'h5A)  begin failures++; $display("FAIL rd_data: got %h want 5a", res_rdat); end
    checks++; if (res_oe_mask != RD_MASK) begin failures++; $display("FAIL rd_n_oe_cycles: got %0h want %0h", res_oe_mask, RD_MASK); end
    checks++; if (res_we_mask != 0)    begin failures++; $display("FAIL rd_n_we_cycles: got %0h want 0", res_we_mask); end
    @(negedge CLK);
    checks++; if (RSP_VALID !== 1'b0)  begin failures++; $display("FAIL rsp_one_cycle: got %b want 0", RSP_VALID); end
  endtask

  task automatic test_back_to_back();
    logic [DEPTH-1:0] addrs [4];
    logic [WIDTH-1:0] datas [4];
    logic             wr    [4];
    addrs = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    datas = '{8'h11, 8'h22, 8'h00, 8'h00};
    wr    = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_req(wr[i], addrs[i], datas[i]);
      if (i > 0) begin
        checks++;
        if (res_stall != 1) begin failures++; $display("FAIL b2b_hold_until_idle[%0d]: stall got %0d want 1", i, res_stall); end
      end
      checks++;
      if (res_rsp_cyc != (wr[i] ? WE+2 : RD+2)) begin
        failures++; $display("FAIL b2b_rsp_cycle[%0d]: got %0d want %0d", i, res_rsp_cyc, wr[i] ? WE+2 : RD+2);
      end
      checks++;
      if (res_viol != 0) begin failures++; $display("FAIL b2b_pin_rules[%0d]: got %0d violations want 0", i, res_viol); end
      if (!wr[i]) begin
        checks++;
        if (res_rdat !== datas[i-2]) begin failures++; $display("FAIL b2b_read[%0d]: got %h want %h", i, res_rdat, datas[i-2]); end
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_rsp_data_hold();
    run_req(1'b1, 12'h010, 8'h77);
    run_req(1'b0, 12'h010, 8'h00);
    checks++; if (res_rdat !== 8'h77) begin failures++; $display("FAIL hold_read: got %h want 77", res_rdat); end
    run_req(1'b1, 12'h020, 8'h99);
    checks++; if (res_rw !== 1'b1)    begin failures++; $display("FAIL hold_wr_rsp_write: got %b want 1", res_rw); end
    checks++; if (RSP_DATA !== 8'h77) begin failures++; $display("FAIL hold_rsp_data_at_wr: got %h want 77", RSP_DATA); end
    repeat (3) @(negedge CLK);
    checks++; if (RSP_DATA !== 8'h77) begin failures++; $display("FAIL hold_rsp_data_after: got %h want 77", RSP_DATA); end
  endtask

  task automatic test_reset_mid_write();
    int waited = 0;
    int pulses = 0;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 12'h040; REQ_DATA = 8'hAB;
    while (REQ_READY !== 1'b1 && waited < 50) begin @(negedge CLK); waited++; end
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL rst_mid_accept: ready got %b want 1", REQ_READY); end
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (N_WE !== 1'b0) begin failures++; $display("FAIL rst_mid_pulse_started: N_WE got %b want 0", N_WE); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (N_WE !== 1'b1)      begin failures++; $display("FAIL rst_mid_n_we: got %b want 1", N_WE); end
    checks++; if (N_OE !== 1'b1)      begin failures++; $display("FAIL rst_mid_n_oe: got %b want 1", N_OE); end
    checks++; if (ADDR !== '0)        begin failures++; $display("FAIL rst_mid_addr: got %h want 000", ADDR); end
    checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL rst_mid_ready: got %b want 0", REQ_READY); end
    if (RSP_VALID === 1'b1) pulses++;
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL rst_mid_ready_after: got %b want 1", REQ_READY); end
    repeat (8) begin
      if (RSP_VALID === 1'b1) pulses++;
      @(negedge CLK);
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rst_mid_no_rsp: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_random_stream();
    logic [WIDTH-1:0] sb [int];
    logic             w;
    logic [DEPTH-1:0] a;
    logic [WIDTH-1:0] d;
    int               reads_checked = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'($urandom);
        REQ_ADDR  = DEPTH'($urandom);
        @(negedge CLK);
      end
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? DEPTH'($urandom) : DEPTH'($urandom_range(0, 15));
      d = WIDTH'($urandom);
      run_req(w, a, d);
      checks++;
      if (res_stall < 0 || res_rsp_cyc == 0) begin
        failures++; $display("FAIL rnd_timeout[%0d]: stall %0d rsp_cycle %0d", i, res_stall, res_rsp_cyc);
        continue;
      end
      checks++;
      if (res_rsp_cyc != (w ? WE+2 : RD+2)) begin
        failures++; $display("FAIL rnd_rsp_cycle[%0d]: got %0d want %0d", i, res_rsp_cyc, w ? WE+2 : RD+2);
      end
      checks++;
      if (res_viol != 0) begin failures++; $display("FAIL rnd_pin_rules[%0d]: got %0d violations want 0", i, res_viol); end
      checks++;
      if (res_rw !== w) begin failures++; $display("FAIL rnd_rsp_write[%0d]: got %b want %b", i, res_rw, w); end
      checks++;
      if (res_we_mask != (w ? WR_MASK : 0) || res_oe_mask != (w ? 0 : RD_MASK)) begin
        failures++; $display("FAIL rnd_strobes[%0d]: we %0h oe %0h want we %0h oe %0h",
                             i, res_we_mask, res_oe_mask, w ? WR_MASK : 0, w ? 0 : RD_MASK);
      end
      if (w) begin
        sb[int'(a)] = d;
      end else if (sb.exists(int'(a))) begin
        reads_checked++;
        checks++;
        if (res_rdat !== sb[int'(a)]) begin
          failures++; $display("FAIL rnd_read[%0d] addr %h: got %h want %h", i, a, res_rdat, sb[int'(a)]);
        end
      end
    end
    checks++;
    if (reads_checked < 50) begin failures++; $display("FAIL rnd_read_coverage: got %0d scored reads want >= 50", reads_checked); end
    REQ_VALID = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_DATA = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rsp_data_hold();
    test_reset_mid_write();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
